// File: rtl/xyolo_read_pp_pkg.sv
// Shared constants, state encodings and width helpers for the ping/pong
// weight/bias reader.
package xyolo_read_pp_pkg;

  localparam logic [2:0] XYOLO_READ_PP_CONF_EXT_ADDR = 3'd0;
  localparam logic [2:0] XYOLO_READ_PP_CONF_OFFSET   = 3'd1;
  localparam logic [2:0] XYOLO_READ_PP_CONF_LEN      = 3'd2;
  localparam logic [2:0] XYOLO_READ_PP_CONF_RD_START = 3'd3;
  localparam logic [2:0] XYOLO_READ_PP_CONF_RD_LEN   = 3'd4;
  localparam logic [2:0] XYOLO_READ_PP_CONF_RD_REP   = 3'd5;
  localparam logic [2:0] XYOLO_READ_PP_CONF_CTRL     = 3'd6;

  localparam int REP_W = 16;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_NEXT = 2'd2
  } fill_state_t;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_RD   = 1'b1
  } drain_state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xyolo_read_pp_if.sv
// Single-outstanding read databus between the reader (master) and memory.
interface xyolo_read_pp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_2p_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
module iob_2p_mem #(
  parameter int W = 32,
  parameter int A = 11
) (
  input  logic         clk,
  input  logic         w_en,
  input  logic [A-1:0] w_addr,
  input  logic [W-1:0] w_data,
  input  logic         r_en,
  input  logic [A-1:0] r_addr,
  output logic [W-1:0] r_data
);
  logic [W-1:0] mem_r [2**A];

  // write port
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem_r[w_addr] <= w_data;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (r_en) begin
      r_data <= mem_r[r_addr];
    end
  end
endmodule

// File: rtl/xyolo_read_pp_fill.sv
// Fill sequencer: walks channels and words channel-major, issues one bus read
// at a time and produces the RAM/bias write strobes on each completion.
module xyolo_read_pp_fill
  import xyolo_read_pp_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10,
  localparam int CH_W      = cnt_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  start_en,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     offset,
  input  logic [MEM_ADDR_W:0]   len,
  input  logic                  wsel,
  input  logic                  bias_en,
  output logic                  req_valid,
  output logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  mem_we,
  output logic [CH_W-1:0]       mem_ch,
  output logic [MEM_ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  output logic                  bias_we
);
  localparam logic [ADDR_W-1:0]   BYTES_INC = ADDR_W'(bytes_of(DATA_W));
  localparam logic [MEM_ADDR_W:0] ONE_LEN   = (MEM_ADDR_W+1)'(1'b1);
  localparam logic [CH_W-1:0]     LAST_CH   = CH_W'(N_CH - 1);

  fill_state_t           state_r;
  logic [CH_W-1:0]       c_r;
  logic [MEM_ADDR_W-1:0] k_r;
  logic [ADDR_W-1:0]     base_r;
  logic                  valid_r;
  logic [ADDR_W-1:0]     addr_r;
  logic                  last_k_s;
  logic                  last_c_s;
  logic                  done_req_s;

  assign last_k_s   = ({1'b0, k_r} == (len - ONE_LEN));
  assign last_c_s   = (c_r == LAST_CH);
  assign done_req_s = (state_r == FILL_REQ) && ready;

  // fill FSM; base_r accumulates c*OFFSET so no multiplier is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL_IDLE;
      c_r     <= {CH_W{1'b0}};
      k_r     <= {MEM_ADDR_W{1'b0}};
      base_r  <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        FILL_IDLE: begin
          if (start && start_en) begin
            state_r <= FILL_REQ;
            valid_r <= 1'b1;
            addr_r  <= start_addr;
            base_r  <= start_addr;
            c_r     <= {CH_W{1'b0}};
            k_r     <= {MEM_ADDR_W{1'b0}};
          end
        end
        FILL_REQ: begin
          if (ready) begin
            valid_r <= 1'b0;
            if (last_k_s) begin
              k_r     <= {MEM_ADDR_W{1'b0}};
              c_r     <= c_r + CH_W'(1'b1);
              base_r  <= base_r + offset;
              addr_r  <= base_r + offset;
              state_r <= last_c_s ? FILL_IDLE : FILL_NEXT;
            end else begin
              k_r     <= k_r + MEM_ADDR_W'(1'b1);
              addr_r  <= addr_r + BYTES_INC;
              state_r <= FILL_NEXT;
            end
          end
        end
        FILL_NEXT: begin
          state_r <= FILL_REQ;
          valid_r <= 1'b1;
        end
        default: begin
          state_r <= FILL_IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid = valid_r;
  assign req_addr  = addr_r;
  assign busy      = (state_r != FILL_IDLE);
  assign mem_we    = done_req_s;
  assign mem_ch    = c_r;
  assign mem_addr  = {wsel, k_r};
  assign mem_data  = rdata;
  assign bias_we   = done_req_s && bias_en && (k_r == {MEM_ADDR_W{1'b0}});
endmodule

// File: rtl/xyolo_read_pp.sv
// Ping/pong weight/bias reader: fills one buffer half from the databus while
// streaming the other half out as a lock-step N_CH-wide word stream.
module xyolo_read_pp
  import xyolo_read_pp_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     run,
  output logic                     done,
  input  logic                     valid,
  input  logic [2:0]               addr,
  input  logic [ADDR_W-1:0]        wdata,
  input  logic                     wstrb,
  xyolo_read_pp_if.master          databus,
  output logic [N_CH*DATA_W-1:0]   flow_out_weight,
  output logic [N_CH*DATA_W-1:0]   flow_out_bias,
  output logic                     flow_out_valid
);
  localparam int CH_W = cnt_w(N_CH);
  localparam logic [ADDR_W-1:0]     LEN_MAX_W = ADDR_W'(1'b1) << MEM_ADDR_W;
  localparam logic [MEM_ADDR_W:0]   LEN_MAX   = {1'b1, {MEM_ADDR_W{1'b0}}};
  localparam logic [MEM_ADDR_W:0]   ONE_LEN   = (MEM_ADDR_W+1)'(1'b1);
  localparam logic [REP_W-1:0]      ONE_REP   = REP_W'(1'b1);

  logic [ADDR_W-1:0]     cfg_ext_addr_r, cfg_offset_r;
  logic [MEM_ADDR_W:0]   cfg_len_r, cfg_rd_len_r, len_sat_s;
  logic [MEM_ADDR_W-1:0] cfg_rd_start_r;
  logic [REP_W-1:0]      cfg_rd_rep_r;
  logic                  cfg_bias_en_r;

  logic [ADDR_W-1:0]     sh_offset_r;
  logic [MEM_ADDR_W:0]   sh_len_r, sh_rd_len_r;
  logic [MEM_ADDR_W-1:0] sh_rd_start_r;
  logic [REP_W-1:0]      sh_rd_rep_r;
  logic                  sh_bias_en_r;

  logic                  wsel_r, wsel_next_s, done_r, accept_s, idle_s;
  logic [N_CH*DATA_W-1:0] bias_out_r, weight_r, ram_pack_s;
  logic [DATA_W-1:0]     bias_r [2][N_CH];
  logic [DATA_W-1:0]     ram_q_s [N_CH];

  logic                  fill_busy_s, mem_we_s, bias_we_s;
  logic [CH_W-1:0]       mem_ch_s;
  logic [MEM_ADDR_W:0]   mem_addr_s, rd_mem_addr_s;
  logic [DATA_W-1:0]     mem_data_s;

  drain_state_t          drain_state_r;
  logic [MEM_ADDR_W-1:0] rd_addr_r;
  logic [MEM_ADDR_W:0]   rd_idx_r;
  logic [REP_W-1:0]      rep_cnt_r;
  logic                  pipe_v_r, flow_out_valid_r, rd_en_s;

  assign accept_s    = run && done_r;
  assign wsel_next_s = wsel_r ^ (|sh_len_r);
  assign rd_en_s     = (drain_state_r == DRAIN_RD);
  assign rd_mem_addr_s = {~wsel_r, rd_addr_r};
  assign idle_s      = !fill_busy_s && !rd_en_s && !pipe_v_r && !flow_out_valid_r;

  // LEN saturates at one full half
  always_comb begin
    if (wdata > LEN_MAX_W) begin
      len_sat_s = LEN_MAX;
    end else begin
      len_sat_s = wdata[MEM_ADDR_W:0];
    end
  end

  // config register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      cfg_ext_addr_r <= {ADDR_W{1'b0}};
      cfg_offset_r   <= {ADDR_W{1'b0}};
      cfg_len_r      <= {(MEM_ADDR_W+1){1'b0}};
      cfg_rd_start_r <= {MEM_ADDR_W{1'b0}};
      cfg_rd_len_r   <= {(MEM_ADDR_W+1){1'b0}};
      cfg_rd_rep_r   <= {REP_W{1'b0}};
      cfg_bias_en_r  <= 1'b0;
    end else if (valid && wstrb) begin
      case (addr)
        XYOLO_READ_PP_CONF_EXT_ADDR: cfg_ext_addr_r <= wdata;
        XYOLO_READ_PP_CONF_OFFSET:   cfg_offset_r   <= wdata;
        XYOLO_READ_PP_CONF_LEN:      cfg_len_r      <= len_sat_s;
        XYOLO_READ_PP_CONF_RD_START: cfg_rd_start_r <= wdata[MEM_ADDR_W-1:0];
        XYOLO_READ_PP_CONF_RD_LEN:   cfg_rd_len_r   <= wdata[MEM_ADDR_W:0];
        XYOLO_READ_PP_CONF_RD_REP:   cfg_rd_rep_r   <= wdata[REP_W-1:0];
        XYOLO_READ_PP_CONF_CTRL:     cfg_bias_en_r  <= wdata[0];
        default: begin end
      endcase
    end
  end

  // run acceptance: shadows, half select, drained-half bias, done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_offset_r   <= {ADDR_W{1'b0}};
      sh_len_r      <= {(MEM_ADDR_W+1){1'b0}};
      sh_rd_start_r <= {MEM_ADDR_W{1'b0}};
      sh_rd_len_r   <= {(MEM_ADDR_W+1){1'b0}};
      sh_rd_rep_r   <= {REP_W{1'b0}};
      sh_bias_en_r  <= 1'b0;
      wsel_r        <= 1'b0;
      done_r        <= 1'b1;
      bias_out_r    <= {(N_CH*DATA_W){1'b0}};
    end else if (accept_s) begin
      sh_offset_r   <= cfg_offset_r;
      sh_len_r      <= cfg_len_r;
      sh_rd_start_r <= cfg_rd_start_r;
      sh_rd_len_r   <= cfg_rd_len_r;
      sh_rd_rep_r   <= cfg_rd_rep_r;
      sh_bias_en_r  <= cfg_bias_en_r;
      wsel_r        <= wsel_next_s;
      done_r        <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        bias_out_r[(N_CH-1-i)*DATA_W +: DATA_W] <= bias_r[~wsel_next_s][i];
      end
    end else if (!done_r && idle_s) begin
      done_r <= 1'b1;
    end
  end

  xyolo_read_pp_fill #(
    .N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .start      (accept_s),
    .start_en   (|cfg_len_r),
    .start_addr (cfg_ext_addr_r),
    .offset     (sh_offset_r),
    .len        (sh_len_r),
    .wsel       (wsel_r),
    .bias_en    (sh_bias_en_r),
    .req_valid  (databus.valid),
    .req_addr   (databus.addr),
    .rdata      (databus.rdata),
    .ready      (databus.ready),
    .busy       (fill_busy_s),
    .mem_we     (mem_we_s),
    .mem_ch     (mem_ch_s),
    .mem_addr   (mem_addr_s),
    .mem_data   (mem_data_s),
    .bias_we    (bias_we_s)
  );

  assign databus.wdata = {DATA_W{1'b0}};
  assign databus.wstrb = {(DATA_W/8){1'b0}};

  // per-half bias capture of word 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < 2; h++) begin
        for (int i = 0; i < N_CH; i++) begin
          bias_r[h][i] <= {DATA_W{1'b0}};
        end
      end
    end else if (bias_we_s) begin
      bias_r[wsel_r][mem_ch_s] <= mem_data_s;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    iob_2p_mem #(.W(DATA_W), .A(MEM_ADDR_W+1)) u_mem (
      .clk    (clk),
      .w_en   (mem_we_s && (mem_ch_s == CH_W'(ch))),
      .w_addr (mem_addr_s),
      .w_data (mem_data_s),
      .r_en   (rd_en_s),
      .r_addr (rd_mem_addr_s),
      .r_data (ram_q_s[ch])
    );
  end

  // drain address generator, wrapping within the drained half
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_state_r <= DRAIN_IDLE;
      rd_addr_r     <= {MEM_ADDR_W{1'b0}};
      rd_idx_r      <= {(MEM_ADDR_W+1){1'b0}};
      rep_cnt_r     <= {REP_W{1'b0}};
    end else begin
      case (drain_state_r)
        DRAIN_IDLE: begin
          if (accept_s && (|cfg_rd_len_r) && (|cfg_rd_rep_r)) begin
            drain_state_r <= DRAIN_RD;
            rd_addr_r     <= cfg_rd_start_r;
            rd_idx_r      <= {(MEM_ADDR_W+1){1'b0}};
            rep_cnt_r     <= {REP_W{1'b0}};
          end
        end
        DRAIN_RD: begin
          if (rd_idx_r == (sh_rd_len_r - ONE_LEN)) begin
            rd_idx_r  <= {(MEM_ADDR_W+1){1'b0}};
            rd_addr_r <= sh_rd_start_r;
            if (rep_cnt_r == (sh_rd_rep_r - ONE_REP)) begin
              drain_state_r <= DRAIN_IDLE;
            end else begin
              rep_cnt_r <= rep_cnt_r + ONE_REP;
            end
          end else begin
            rd_idx_r  <= rd_idx_r + ONE_LEN;
            rd_addr_r <= rd_addr_r + MEM_ADDR_W'(1'b1);
          end
        end
        default: drain_state_r <= DRAIN_IDLE;
      endcase
    end
  end

  // channel 0 lands in the MSBs
  always_comb begin
    ram_pack_s = {(N_CH*DATA_W){1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      ram_pack_s[(N_CH-1-i)*DATA_W +: DATA_W] = ram_q_s[i];
    end
  end

  // output register stage behind the RAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v_r         <= 1'b0;
      flow_out_valid_r <= 1'b0;
      weight_r         <= {(N_CH*DATA_W){1'b0}};
    end else begin
      pipe_v_r         <= rd_en_s;
      flow_out_valid_r <= pipe_v_r;
      if (pipe_v_r) begin
        weight_r <= ram_pack_s;
      end
    end
  end

  assign done            = done_r;
  assign flow_out_weight = weight_r;
  assign flow_out_bias   = bias_out_r;
  assign flow_out_valid  = flow_out_valid_r;
endmodule

// File: tb/tb_xyolo_read_pp.sv
// Directed self-checking bench for xyolo_read_pp with a responding memory model.
module tb_xyolo_read_pp;
  localparam int N_CH = 4, DATA_W = 32, ADDR_W = 32, MEM_ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0, run = 1'b0, valid = 1'b0, wstrb = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic done, fov;
  logic [127:0] fow, fob;

  xyolo_read_pp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) db ();

  xyolo_read_pp #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run), .done(done),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .databus(db),
    .flow_out_weight(fow), .flow_out_bias(fob), .flow_out_valid(fov)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ready_mode = 0, stall_cnt = 0;
  bit mon_en = 1'b0, prev_pending = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] req_q[$];
  logic [7:0] pat = 8'hA1;
  bit bias_pat = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [7:0] p, input bit bp);
    if (bp && a[7:0] == 8'h00) return 32'hB0 + {30'd0, a[9:8]};
    return {p, a[23:0]};
  endfunction

  function automatic logic [127:0] beat(input int k, input logic [7:0] p, input bit bp);
    logic [127:0] r;
    r = 128'd0;
    for (int c = 0; c < 4; c++)
      r[(3-c)*32 +: 32] = mem_word(32'h1000 + 32'(c) * 32'h100 + 32'(k) * 32'd4, p, bp);
    return r;
  endfunction

  always_comb db.rdata = mem_word(db.addr, pat, bias_pat);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ready generation followed by bus protocol monitoring
  always @(negedge clk) begin
    case (ready_mode)
      0: db.ready = 1'b1;
      1: begin
        if (stall_cnt >= 5 || $urandom_range(0, 2) == 0) begin
          db.ready = 1'b1; stall_cnt = 0;
        end else begin
          db.ready = 1'b0; stall_cnt++;
        end
      end
      default: db.ready = 1'b0;
    endcase
    if (mon_en) begin
      if (prev_pending) begin
        check("hold_valid", {127'd0, db.valid}, 128'd1);
        check("hold_addr", {96'd0, db.addr}, {96'd0, prev_addr});
      end
      if (prev_hs) check("gap", {127'd0, db.valid}, 128'd0);
      if (db.valid && db.ready) req_q.push_back(db.addr);
      prev_pending = db.valid && !db.ready;
      prev_hs      = db.valid && db.ready;
      prev_addr    = db.addr;
    end else begin
      prev_pending = 1'b0;
      prev_hs      = 1'b0;
    end
  end

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic run_pulse();
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_timeout", {127'd0, done}, 128'd1);
  endtask

  task automatic check_reqs(input string tag);
    check({tag, "_count"}, 128'(req_q.size()), 128'd12);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 3; k++)
        check(tag, {96'd0, req_q[c*3+k]}, 128'(32'h1000 + 32'(c) * 32'h100 + 32'(k) * 32'd4));
  endtask

  initial begin
    int done_at;
    repeat (3) @(negedge clk);
    check("rst_done", {127'd0, done}, 128'd1);
    check("rst_valid", {127'd0, db.valid}, 128'd0);
    check("rst_addr", {96'd0, db.addr}, 128'd0);
    check("rst_fov", {127'd0, fov}, 128'd0);
    check("rst_weight", fow, 128'd0);
    check("rst_bias", fob, 128'd0);
    rst = 1'b0;

    // run 1: fill half 0, ready always high, bias capture on
    cfg(3'd0, 32'h1000); cfg(3'd1, 32'h100); cfg(3'd2, 32'd3); cfg(3'd6, 32'd1);
    req_q.delete(); mon_en = 1'b1;
    run_pulse();
    done_at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("r1_done_fall", {127'd0, done}, 128'd0);
        check("r1_first_valid", {127'd0, db.valid}, 128'd1);
        check("r1_first_addr", {96'd0, db.addr}, 128'h1000);
      end
      if (done) begin done_at = n; break; end
    end
    check("r1_done_latency", 128'(done_at), 128'd25);
    check_reqs("r1_addr");

    // run 2: stalled fill of half 1 while half 0 drains 0,1,2,0,1,2
    pat = 8'hC2; bias_pat = 1'b0; ready_mode = 1;
    cfg(3'd6, 32'd0); cfg(3'd3, 32'd0); cfg(3'd4, 32'd3); cfg(3'd5, 32'd2);
    req_q.delete();
    run_pulse();
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) check("r2_bias", fob, 128'h000000B0_000000B1_000000B2_000000B3);
      if (n <= 2) check("r2_fov_lo", {127'd0, fov}, 128'd0);
      else if (n <= 8) begin
        check("r2_fov_hi", {127'd0, fov}, 128'd1);
        check("r2_weight", fow, beat((n - 3) % 3, 8'hA1, 1'b1));
      end else begin
        check("r2_fov_end", {127'd0, fov}, 128'd0);
        check("r2_weight_hold", fow, beat(2, 8'hA1, 1'b1));
      end
    end
    check("r2_busy", {127'd0, done}, 128'd0);
    cfg(3'd2, 32'd1);
    run_pulse();
    wait_done();
    check_reqs("r2_addr");

    // run 3: LEN=0, drain half 1 to verify the stalled fill contents
    ready_mode = 0;
    cfg(3'd2, 32'd0); cfg(3'd5, 32'd1);
    req_q.delete();
    run_pulse();
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) check("r3_bias", fob, 128'd0);
      check("r3_no_req", {127'd0, db.valid}, 128'd0);
      if (n >= 3 && n <= 5) begin
        check("r3_fov", {127'd0, fov}, 128'd1);
        check("r3_weight", fow, beat(n - 3, 8'hC2, 1'b0));
      end
    end
    wait_done();
    check("r3_req_count", 128'(req_q.size()), 128'd0);

    // run 4: previous LEN=0 keeps wsel, so half 1 is drained again
    cfg(3'd3, 32'd1); cfg(3'd4, 32'd1);
    run_pulse();
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 3) begin
        check("r4_fov", {127'd0, fov}, 128'd1);
        check("r4_weight", fow, beat(1, 8'hC2, 1'b0));
      end
      if (n == 4) check("r4_fov_end", {127'd0, fov}, 128'd0);
    end
    wait_done();

    // run 5: reset while a request is pending and the drain is streaming
    mon_en = 1'b0; ready_mode = 2;
    cfg(3'd0, 32'h2000); cfg(3'd2, 32'd3); cfg(3'd3, 32'd0); cfg(3'd4, 32'd3); cfg(3'd5, 32'd4);
    run_pulse();
    repeat (4) @(negedge clk);
    check("r5_valid_pre", {127'd0, db.valid}, 128'd1);
    check("r5_addr_pre", {96'd0, db.addr}, 128'h2000);
    check("r5_fov_pre", {127'd0, fov}, 128'd1);
    #2 rst = 1'b1;
    #1;
    check("r5_rst_valid", {127'd0, db.valid}, 128'd0);
    check("r5_rst_done", {127'd0, done}, 128'd1);
    check("r5_rst_fov", {127'd0, fov}, 128'd0);
    @(negedge clk);
    rst = 1'b0; ready_mode = 0;

    // clear zeroes config: the next run does nothing
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    req_q.delete(); mon_en = 1'b1;
    run_pulse();
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) check("r6_done_fall", {127'd0, done}, 128'd0);
      if (n == 2) check("r6_done_rise", {127'd0, done}, 128'd1);
      check("r6_no_req", {127'd0, db.valid}, 128'd0);
      check("r6_no_fov", {127'd0, fov}, 128'd0);
    end
    check("r6_req_count", 128'(req_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xyolo_read_pp.md
Name: xyolo_read_pp

Overview:
Parametrised successor to the YOLO weight/bias reader. It fetches N_CH per-channel weight vectors from external memory over a single databus master, one outstanding request at a time. Fetched words go into per-channel dual-port buffers organised as explicit ping/pong halves. Concurrently it drains the other half as a lock-step N_CH-wide stream, with a per-half bias capture and a flow_out_valid qualifier.

Parameters:
N_CH, 4, number of channels (1..16)
DATA_W, 32, word width; byte increment BYTES=DATA_W/8
ADDR_W, 32, external byte address width
MEM_ADDR_W, 10, per-half buffer depth log2; each channel RAM is 2^(MEM_ADDR_W+1) words

Ports:
clk  in  1  clock
rst  in  1  reset
clear  in  1  synchronous clear of config registers
run  in  1  start pulse; accepted only when done=1
done  out  1  fill and drain both idle
valid  in  1  config write request
addr  in  3  config register select
wdata  in  ADDR_W  config data
wstrb  in  1  write qualifier
databus_valid  out  1  read request
databus_addr  out  ADDR_W  byte address
databus_rdata  in  DATA_W  read data, valid when databus_ready=1
databus_ready  in  1  request completed this cycle
databus_wdata  out  DATA_W  tied 0
databus_wstrb  out  DATA_W/8  tied 0
flow_out_weight  out  N_CH*DATA_W  channel 0 in MSBs
flow_out_bias  out  N_CH*DATA_W  bias of the half being drained
flow_out_valid  out  1  flow_out_weight valid this cycle

Behaviour:
- Reset rst is asynchronous, active-high; clock clk.
- Reset values: done=1, databus_valid=0, databus_addr=0, flow_out_valid=0, flow_out_weight=0, flow_out_bias=0, all config/shadow registers 0, wsel=0.
- Config map (written on valid&wstrb):
  - 0 EXT_ADDR
  - 1 OFFSET (channel byte stride)
  - 2 LEN (words per channel, MEM_ADDR_W+1 bits; LEN>2^MEM_ADDR_W saturates to 2^MEM_ADDR_W)
  - 3 RD_START
  - 4 RD_LEN
  - 5 RD_REP (repetitions)
  - 6 CTRL (bit0 bias_en)
  - 7 reserved, ignored
- clear zeroes config registers only; it does not affect shadows, FSMs or outputs.
- run accepted (done=1, run=1) in cycle T:
  - All config is copied to shadows.
  - wsel toggles if the previous accepted run had LEN≠0; the first run after reset keeps wsel=0.
  - Fill writes half wsel. Drain reads half ~wsel.
  - done falls at T+1.
- run while done=0 is ignored; no state changes.
- Fill FSM: IDLE -> REQ -> (NEXT) -> IDLE.
  - REQ drives databus_valid=1 with addr = EXT_ADDR + c*OFFSET + k*BYTES (mod 2^ADDR_W). Address and valid are held stable until ready.
  - On ready, rdata is written to channel c RAM at {wsel,k}. Order is channel-major: k runs 0..LEN-1 inside c runs 0..N_CH-1.
  - databus_valid drops for exactly one cycle between requests (NEXT); the first REQ is at T+1.
  - LEN=0: fill FSM stays IDLE.
- Bias: if bias_en, word k=0 of channel c is also latched into bias[wsel][c] in its ready cycle. Bias of the current fill half is not visible on flow_out_bias until that half is drained.
- Drain FSM: IDLE -> RD -> IDLE.
  - Read address runs RD_START..RD_START+RD_LEN-1 (wrapping mod 2^MEM_ADDR_W within half ~wsel), repeated RD_REP times.
  - One address per cycle; first read at T+1.
  - RAM registered read plus an output register: flow_out_valid first high at T+3, then contiguous for RD_LEN*RD_REP cycles.
  - RD_LEN=0 or RD_REP=0: drain stays IDLE.
- flow_out_bias = bias[~wsel] registered, updated at T+1.
- flow_out_weight holds its last value when flow_out_valid=0.
- done rises the cycle after both FSMs are IDLE and the drain pipeline is empty.
- A RAM write and read to the same address cannot occur, since the halves differ.
- rst asserted mid-operation aborts both FSMs immediately and drops databus_valid. RAM contents are undefined after reset.

Decomposition:
- Package xyolo_read_pp_pkg holds:
  - Config address constants (XYOLO_READ_PP_CONF_*).
  - Fill/drain state encodings.
  - Width helper constants: BYTES, count widths.
- Sub-module xyolo_read_pp_fill holds the fill FSM, the c/k counters, the address multiply-add (c*OFFSET incrementally accumulated, no multiplier) and RAM write-port generation.
- Channel RAMs use the existing iob_2p_mem.
- Drain address generation stays in the top level.

Test Plan:
- N_CH=4, EXT_ADDR=0x1000, OFFSET=0x100, LEN=3, ready always 1 -> 12 requests at 0x1000,0x1004,0x1008,0x1100,... each one-cycle-separated, done returns after last write.
- Random ready stalls 0-5 cycles -> databus_addr/valid stable while stalled, RAM contents identical to no-stall run.
- Two runs with patterns A then B, second with RD_START=0, RD_LEN=3, RD_REP=2 -> flow_out_valid at T+3 for 6 cycles streaming A words 0,1,2,0,1,2 while B fills other half.
- bias_en=1, word0 of ch c = 0xB0+c -> after next run, flow_out_bias = {0xB0,0xB1,0xB2,0xB3} at T+1; bias_en=0 leaves bias unchanged.
- run pulse while done=0, and LEN=0 run -> first ignored (no request change); LEN=0 run issues no databus_valid and does not toggle wsel on the following run.
- rst asserted mid-fill with databus_valid=1 -> databus_valid=0, done=1, flow_out_valid=0 immediately; clear during idle zeroes config, so next run issues no requests.
